sync_fifo_rd_ctrl: RTL and testbench

Read-side controller for the 64-QAM symbol FIFO (8 entries, 4-bit gray pointers). It consumes the write pointer after the 2-FF synchronizer and computes fill level and empty. It paces FIFO reads at a fixed symbol rate and publishes its own gray read pointer back toward the write domain. A priming state machine holds off output until enough symbols are buffered, and underruns are counted.

---
 rtl/sync_fifo_pkg.sv | 28 ++
 rtl/sync_fifo_sym_tick_gen.sv | 27 ++
 rtl/sync_fifo_rd_ctrl.sv | 101 ++++++++++
 tb/tb_sync_fifo_rd_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared constants, state encoding and gray-code helpers for the symbol FIFO read side.
package sync_fifo_pkg;

    localparam int FIFO_DEPTH = 8;
    localparam int PTR_W      = 4;
    localparam int ADDR_W     = 3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRIME    = 2'd1,
        RUN      = 2'd2,
        UNDERRUN = 2'd3
    } state_e;

    function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
        logic [PTR_W-1:0] b;
        b[PTR_W-1] = g[PTR_W-1];
        for (int i = PTR_W-2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_fifo_sym_tick_gen.sv
// Symbol-rate divider: counts 0..SYM_DIV-1 while clr is low and flags the last count.
module sync_fifo_sym_tick_gen #(
    parameter int unsigned SYM_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam logic [7:0] LAST = 8'(SYM_DIV - 1);

    logic [7:0] r_cnt;

    assign tick = !clr && (r_cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/sync_fifo_rd_ctrl.sv
// Read-side controller: primes the FIFO, paces reads at the symbol rate and counts underruns.
// state | meaning: IDLE halted | PRIME waiting for fill | RUN streaming | UNDERRUN one-cycle recovery
module sync_fifo_rd_ctrl
    import sync_fifo_pkg::*;
#(
    parameter int unsigned SYM_DIV     = 4,
    parameter int unsigned PRIME_LEVEL = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [PTR_W-1:0]  wr_ptr_gray_sync,
    output logic [PTR_W-1:0]  rd_ptr_gray,
    output logic [ADDR_W-1:0] mem_rd_addr,
    output logic              mem_rd_en,
    output logic              sym_valid,
    output logic              empty,
    output logic [PTR_W-1:0]  fill_level,
    output logic [7:0]        underrun_cnt,
    output logic [1:0]        state
);

    localparam logic [PTR_W-1:0] PRIME_LVL = PTR_W'(PRIME_LEVEL);

    state_e             r_state;
    logic [PTR_W-1:0]   r_rd_bin;
    logic [PTR_W-1:0]   r_rd_ptr_gray;
    logic [ADDR_W-1:0]  r_mem_rd_addr;
    logic               r_mem_rd_en;
    logic               r_sym_valid;
    logic [7:0]         r_underrun_cnt;

    logic [PTR_W-1:0]   w_wr_bin;
    logic [PTR_W-1:0]   w_fill;
    logic               w_empty;
    logic               w_clr;
    logic               w_tick;

    assign w_wr_bin = gray2bin(wr_ptr_gray_sync);
    assign w_fill   = w_wr_bin - r_rd_bin;
    assign w_empty  = (w_fill == '0);
    assign w_clr    = (r_state != RUN);

    sync_fifo_sym_tick_gen #(
        .SYM_DIV (SYM_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_clr),
        .tick  (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_rd_bin       <= '0;
            r_rd_ptr_gray  <= '0;
            r_mem_rd_addr  <= '0;
            r_mem_rd_en    <= 1'b0;
            r_sym_valid    <= 1'b0;
            r_underrun_cnt <= '0;
        end else begin
            r_mem_rd_en <= 1'b0;
            r_sym_valid <= r_mem_rd_en;
            // Dropping enable wins over everything, including a pending pop.
            if (!enable) begin
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: r_state <= PRIME;
                    PRIME: begin
                        if (w_fill >= PRIME_LVL) r_state <= RUN;
                    end
                    RUN: begin
                        if (w_tick && !w_empty) begin
                            r_mem_rd_en   <= 1'b1;
                            r_mem_rd_addr <= r_rd_bin[ADDR_W-1:0];
                            r_rd_bin      <= r_rd_bin + 4'd1;
                            r_rd_ptr_gray <= bin2gray(r_rd_bin + 4'd1);
                        end else if (w_tick) begin
                            r_state <= UNDERRUN;
                            if (r_underrun_cnt != 8'hFF) r_underrun_cnt <= r_underrun_cnt + 8'd1;
                        end
                    end
                    UNDERRUN: r_state <= PRIME;
                    default:  r_state <= IDLE;
                endcase
            end
        end
    end

    assign rd_ptr_gray  = r_rd_ptr_gray;
    assign mem_rd_addr  = r_mem_rd_addr;
    assign mem_rd_en    = r_mem_rd_en;
    assign sym_valid    = r_sym_valid;
    assign empty        = w_empty;
    assign fill_level   = w_fill;
    assign underrun_cnt = r_underrun_cnt;
    assign state        = r_state;

endmodule

// File: tb/tb_sync_fifo_rd_ctrl.sv
// Bench for sync_fifo_rd_ctrl: directed phases plus random writes, with a scoreboard monitor.
module tb_sync_fifo_rd_ctrl;

    localparam int SYM_DIV     = 4;
    localparam int PRIME_LEVEL = 4;
    localparam logic [1:0] S_IDLE = 2'd0, S_PRIME = 2'd1, S_RUN = 2'd2, S_URUN = 2'd3;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic [3:0] wr_ptr_gray_sync;
    logic [3:0] rd_ptr_gray;
    logic [2:0] mem_rd_addr;
    logic       mem_rd_en;
    logic       sym_valid;
    logic       empty;
    logic [3:0] fill_level;
    logic [7:0] underrun_cnt;
    logic [1:0] state;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // driver-owned model state
    int w = 0;
    int exp_q[$];

    // monitor-owned model state
    int rd_idx = 0;
    int exp_pop_cyc = -1;
    int prev_rem = 0;
    int mon_urun = 0;
    logic exp_sv = 1'b0;
    logic [1:0] prev_state = 2'd0;

    sync_fifo_rd_ctrl #(
        .SYM_DIV     (SYM_DIV),
        .PRIME_LEVEL (PRIME_LEVEL)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .enable           (enable),
        .wr_ptr_gray_sync (wr_ptr_gray_sync),
        .rd_ptr_gray      (rd_ptr_gray),
        .mem_rd_addr      (mem_rd_addr),
        .mem_rd_en        (mem_rd_en),
        .sym_valid        (sym_valid),
        .empty            (empty),
        .fill_level       (fill_level),
        .underrun_cnt     (underrun_cnt),
        .state            (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    function automatic logic [3:0] gray4(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_w(input int nw);
        while (w < nw) begin
            exp_q.push_back(w % 8);
            w++;
        end
        wr_ptr_gray_sync = gray4(4'(w));
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget, input string nm);
        int n = 0;
        while (state !== s && n < budget) begin
            step();
            n++;
        end
        chk(nm, state, s);
    endtask

    task automatic wait_pops(input int target, input int budget, input string nm);
        int n = 0;
        while (rd_idx < target && n < budget) begin
            step();
            n++;
        end
        chk(nm, rd_idx, target);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, state, 0);
        chk({tag, "_rd_ptr_gray"}, rd_ptr_gray, 0);
        chk({tag, "_mem_rd_addr"}, mem_rd_addr, 0);
        chk({tag, "_mem_rd_en"}, mem_rd_en, 0);
        chk({tag, "_sym_valid"}, sym_valid, 0);
        chk({tag, "_underrun_cnt"}, underrun_cnt, 0);
        chk({tag, "_fill_level"}, fill_level, 0);
        chk({tag, "_empty"}, empty, 1);
    endtask

    // Monitor: pops are matched against the write-order queue; pacing and counters checked every cycle.
    initial begin
        int rem;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rd_idx      = 0;
                exp_pop_cyc = -1;
                prev_rem    = 0;
                mon_urun    = 0;
                exp_sv      = 1'b0;
                prev_state  = 2'd0;
            end else begin
                chk("sym_valid", sym_valid, exp_sv);
                exp_sv = mem_rd_en;
                if (mem_rd_en) begin
                    chk("pop_avail", (int'(exp_q.size()) - rd_idx) > 0, 1);
                    if (rd_idx < exp_q.size()) chk("pop_addr", mem_rd_addr, exp_q[rd_idx]);
                    chk("pop_time", cyc, exp_pop_cyc);
                    rd_idx++;
                    exp_pop_cyc = cyc + SYM_DIV;
                end else if (state == S_RUN && prev_state == S_RUN && cyc == exp_pop_cyc) begin
                    chk("missed_pop", mem_rd_en, 1);
                end
                if (state == S_URUN && prev_state == S_RUN) begin
                    chk("underrun_at_empty", prev_rem, 0);
                    chk("underrun_time", cyc, exp_pop_cyc);
                    if (mon_urun < 255) mon_urun++;
                end
                if (state == S_RUN && prev_state != S_RUN) exp_pop_cyc = cyc + SYM_DIV;
                if (state != S_RUN) exp_pop_cyc = -1;
                chk("underrun_cnt", underrun_cnt, mon_urun);
                chk("rd_ptr_gray", rd_ptr_gray, gray4(4'(rd_idx)));
                rem = w - rd_idx;
                chk("fill_level", fill_level, rem);
                chk("empty", empty, rem == 0);
                prev_rem   = rem;
                prev_state = state;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        enable = 1'b0;
        wr_ptr_gray_sync = 4'd0;

        // reset with random inputs
        for (int i = 0; i < 5; i++) begin
            enable = 1'($urandom_range(0, 1));
            wr_ptr_gray_sync = 4'($urandom);
            step();
        end
        enable = 1'b0;
        wr_ptr_gray_sync = 4'd0;
        #1;
        chk_reset_vals("reset");
        step();
        rst_n = 1'b1;
        step();

        // prime and run: 4 symbols at addresses 0..3
        set_w(4);
        enable = 1'b1;
        step();
        chk("enter_prime", state, S_PRIME);
        step();
        chk("enter_run", state, S_RUN);
        wait_pops(4, 40, "first_four_pops");
        chk("gray_after_4", rd_ptr_gray, 4'b0110);

        // underrun after draining
        wait_state(S_URUN, 20, "first_underrun");
        chk("underrun_cnt_1", underrun_cnt, 1);
        chk("no_rd_in_urun", mem_rd_en, 0);
        step();
        chk("urun_to_prime", state, S_PRIME);

        // walk the read pointer up to 14, then stream across the wrap
        set_w(10);
        wait_state(S_RUN, 10, "wrap_run_a");
        wait_state(S_URUN, 60, "wrap_urun_a");
        set_w(14);
        wait_state(S_RUN, 10, "wrap_run_b");
        wait_state(S_URUN, 60, "wrap_urun_b");
        chk("gray_before_wrap", rd_ptr_gray, gray4(4'd14));
        set_w(20);
        wait_pops(20, 60, "wrap_pops");
        chk("gray_after_wrap", rd_ptr_gray, 4'b0110);
        wait_state(S_URUN, 20, "wrap_urun_c");

        // enable drop exactly on a tick cycle
        set_w(24);
        wait_state(S_RUN, 10, "drop_run");
        step();
        step();
        step();
        enable = 1'b0;
        step();
        chk("drop_to_idle", state, S_IDLE);
        chk("drop_no_rd", mem_rd_en, 0);
        chk("drop_gray_held", rd_ptr_gray, gray4(4'd4));
        enable = 1'b1;
        step();
        chk("reenable_prime", state, S_PRIME);
        wait_state(S_RUN, 10, "reenable_run");
        wait_pops(24, 40, "reenable_pops");
        chk("reenable_gray", rd_ptr_gray, gray4(4'd8));
        wait_state(S_URUN, 20, "reenable_urun");

        // random writes with occasional enable drops
        for (int i = 0; i < 1500; i++) begin
            step();
            if ($urandom_range(0, 3) == 0 && (w - rd_idx) < 8) set_w(w + 1);
            if ($urandom_range(0, 99) == 0) enable = 1'b0;
            else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
        end
        enable = 1'b1;
        for (int i = 0; i < 300; i++) step();
        chk("residual_below_prime", (w - rd_idx) < PRIME_LEVEL, 1);

        // fresh reset, then drive the underrun counter into saturation
        rst_n = 1'b0;
        w = 0;
        exp_q.delete();
        wr_ptr_gray_sync = 4'd0;
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 260; i++) begin
            wait_state(S_PRIME, 50, "sat_prime");
            set_w(w + 4);
            wait_state(S_URUN, 60, "sat_urun");
            chk("sat_count", underrun_cnt, (i + 1 > 255) ? 255 : i + 1);
        end
        chk("sat_final", underrun_cnt, 255);

        // asynchronous reset in the middle of a stream
        wait_state(S_PRIME, 50, "midrst_prime");
        set_w(w + 4);
        wait_state(S_RUN, 10, "midrst_run");
        begin
            int n = 0;
            while (mem_rd_en !== 1'b1 && n < 20) begin
                step();
                n++;
            end
            chk("midrst_pop_seen", mem_rd_en, 1);
        end
        #2;
        rst_n = 1'b0;
        w = 0;
        exp_q.delete();
        wr_ptr_gray_sync = 4'd0;
        #1;
        chk_reset_vals("midrst");
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("post_reset_idle_prime", state, S_PRIME);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
